// File: rtl/synaptic_input_driver.sv
// -----------------------------------------------------------------------------
// synaptic_input_driver
//
// Receive end of the spike path. Weighted presynaptic spike events are queued
// in a small FIFO. On every timestep request the block decays the synaptic
// current, folds in every event that was queued before the step, and publishes
// the result (the neuron input current) with a one-cycle valid pulse.
// All values are signed fixed-point, N bits wide with Q fractional bits.
//
// Optional feature macro: SYNAPTIC_SATURATE_EN
//   defined   -> accumulation adds saturate to the most positive/negative value
//   undefined -> accumulation adds wrap (plain N-bit two's complement)
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst_n        in   asynchronous active-low reset
//   ev_valid     in   spike event offered
//   ev_ready     out  FIFO can accept an event this cycle
//   ev_weight    in   signed synaptic weight of the offered event
//   step         in   timestep advance request (acted on only when idle)
//   busy         out  high while a timestep is being processed
//   i_out        out  published synaptic current
//   i_valid      out  one-cycle pulse when i_out has just been updated
//   fifo_count   out  number of queued events
//   step_overrun out  sticky flag: a step arrived while busy
// -----------------------------------------------------------------------------
module synaptic_input_driver #(
    parameter int N           = 32,
    parameter int Q           = 16,
    parameter int DEPTH       = 8,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ev_valid,
    output logic                     ev_ready,
    input  logic [N-1:0]             ev_weight,
    input  logic                     step,
    output logic                     busy,
    output logic [N-1:0]             i_out,
    output logic                     i_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     step_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Elaboration-time sanity check of the configuration.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || Q >= N || DECAY_SHIFT >= N) begin : g_bad_params
            $error("synaptic_input_driver: invalid parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DECAY   = 2'd1,
        S_DRAIN   = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

    state_t                 state_q;
    logic signed [N-1:0]    acc_q;
    logic [N-1:0]           i_out_q;
    logic                   i_valid_q;
    logic                   overrun_q;
    logic [CW-1:0]          snap_q;

    // FIFO storage and pointers
    logic [N-1:0]           mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [CW-1:0]          count_q;

    logic                   push;
    logic                   pop;
    logic [N-1:0]           head;
    logic signed [N-1:0]    acc_decay_d;
    logic signed [N-1:0]    acc_sum_d;

    // Ready depends only on the registered count, so a pop in the same cycle
    // never opens an extra slot.
    assign ev_ready = (count_q < CW'(DEPTH));
    assign push     = ev_valid && ev_ready;
    // DRAIN is only entered with snap > 0 and the FIFO holds at least snap
    // entries, so every DRAIN cycle has a valid head to pop.
    assign pop      = (state_q == S_DRAIN);

    // Asynchronous read of the head entry: DRAIN consumes one entry per cycle
    // with no bubble, which a registered read could not sustain. The array is
    // tiny, so it maps to distributed RAM.
    assign head = mem_q[rd_ptr_q];

    // Arithmetic shift floors, so negative currents also move toward zero.
    // x - (x >>> s) cannot overflow for s >= 1 (and s == 0 yields exactly 0).
    assign acc_decay_d = acc_q - (acc_q >>> DECAY_SHIFT);

`ifdef SYNAPTIC_SATURATE_EN
    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
    logic [N-1:0] sum_raw;
    logic         sum_ovf;
    assign sum_raw = acc_q + head;
    // Overflow only when both operands share a sign and the result flips it.
    assign sum_ovf = (acc_q[N-1] == head[N-1]) && (sum_raw[N-1] != acc_q[N-1]);
    assign acc_sum_d = sum_ovf ? (acc_q[N-1] ? MIN_NEG : MAX_POS) : sum_raw;
`else
    assign acc_sum_d = acc_q + head;
`endif

    // FIFO storage: no reset needed, emptiness is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ev_weight;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            i_out_q   <= '0;
            i_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            snap_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            // FIFO bookkeeping runs in every state.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);

            i_valid_q <= 1'b0;

            if (step && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (step) begin
                        // Registered count excludes a push on this same edge,
                        // so late events wait for the next step.
                        snap_q  <= count_q;
                        state_q <= S_DECAY;
                    end
                end
                S_DECAY: begin
                    acc_q   <= acc_decay_d;
                    state_q <= (snap_q != '0) ? S_DRAIN : S_PUBLISH;
                end
                S_DRAIN: begin
                    acc_q  <= acc_sum_d;
                    snap_q <= snap_q - CW'(1);
                    if (snap_q == CW'(1)) begin
                        state_q <= S_PUBLISH;
                    end
                end
                S_PUBLISH: begin
                    i_out_q   <= acc_q;
                    i_valid_q <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign i_out        = i_out_q;
    assign i_valid      = i_valid_q;
    assign fifo_count   = count_q;
    assign step_overrun = overrun_q;

endmodule

// File: tb/tb_synaptic_input_driver.sv
// -----------------------------------------------------------------------------
// Directed testbench for synaptic_input_driver. Instance u_dut uses the default
// configuration; u_sat uses DECAY_SHIFT=31 (decay is zero for non-negative
// currents) to exercise accumulation overflow with and without
// SYNAPTIC_SATURATE_EN. Inputs are driven 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_synaptic_input_driver;

    localparam int N  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          ev_valid, ev_ready, step, busy, i_valid, step_overrun;
    logic [N-1:0]  ev_weight, i_out;
    logic [CW-1:0] fifo_count;

    logic          ev_valid_b, ev_ready_b, step_b, busy_b, i_valid_b, step_overrun_b;
    logic [N-1:0]  ev_weight_b, i_out_b;
    logic [CW-1:0] fifo_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    synaptic_input_driver #(.N(32), .Q(16), .DEPTH(8), .DECAY_SHIFT(3)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_weight(ev_weight),
        .step(step), .busy(busy), .i_out(i_out), .i_valid(i_valid),
        .fifo_count(fifo_count), .step_overrun(step_overrun)
    );

    synaptic_input_driver #(.N(32), .Q(16), .DEPTH(8), .DECAY_SHIFT(31)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .ev_valid(ev_valid_b), .ev_ready(ev_ready_b), .ev_weight(ev_weight_b),
        .step(step_b), .busy(busy_b), .i_out(i_out_b), .i_valid(i_valid_b),
        .fifo_count(fifo_count_b), .step_overrun(step_overrun_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sel, input logic [31:0] w);
        if (sel == 0) begin ev_valid = 1'b1; ev_weight = w; end
        else          begin ev_valid_b = 1'b1; ev_weight_b = w; end
        tick();
        ev_valid   = 1'b0;
        ev_valid_b = 1'b0;
    endtask

    // The edge consumed here is E0 of the step.
    task automatic pulse_step(input int sel);
        if (sel == 0) step = 1'b1; else step_b = 1'b1;
        tick();
        step   = 1'b0;
        step_b = 1'b0;
    endtask

    // Called just after E0. Returns the index k of edge E(k) after which
    // i_valid is first seen, or -1 on timeout; also counts busy samples before it.
    task automatic wait_valid(input int sel, input int max_edges,
                              output int edges, output int busy_cnt);
        logic v, b;
        edges    = 0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            v = (sel == 0) ? i_valid : i_valid_b;
            b = (sel == 0) ? busy    : busy_b;
            if (v) break;
            if (b) busy_cnt++;
            if (edges >= max_edges) begin
                edges = -1;
                break;
            end
            tick();
            edges++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, b, k, pulses;
        rst_n = 1'b0;
        ev_valid = 1'b0; ev_weight = '0; step = 1'b0;
        ev_valid_b = 1'b0; ev_weight_b = '0; step_b = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check_eq("rst_i_out",      i_out,        32'h0);
        check_eq("rst_i_valid",    i_valid,      32'h0);
        check_eq("rst_ev_ready",   ev_ready,     32'h1);
        check_eq("rst_busy",       busy,         32'h0);
        check_eq("rst_fifo_count", fifo_count,   32'h0);
        check_eq("rst_overrun",    step_overrun, 32'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- two 1.0 events -> 2.0 ----------------
        push(0, 32'h0001_0000);
        push(0, 32'h0001_0000);
        check_eq("two_ev_count", fifo_count, 32'd2);
        pulse_step(0);
        wait_valid(0, 20, e, b);
        check_eq("two_ev_latency",   e,     32'd4);
        check_eq("two_ev_busy_cnt",  b,     32'd4);
        check_eq("two_ev_busy_done", busy,  32'h0);
        check_eq("two_ev_i_out",     i_out, 32'h0002_0000);
        tick();
        @(negedge clk);
        check_eq("two_ev_valid_pulse", i_valid, 32'h0);
        check_eq("two_ev_fifo_empty",  fifo_count, 32'd0);

        // ---------------- decay only: 2.0 -> 1.75 ----------------
        pulse_step(0);
        wait_valid(0, 20, e, b);
        check_eq("decay_latency", e,     32'd2);
        check_eq("decay_i_out",   i_out, 32'h0001_C000);
        tick();

        // ---------------- negative current ----------------
        // 1.75 decays to 1.53125 (0x18800); add -3.53125 -> -2.0
        push(0, 32'hFFFC_7800);
        pulse_step(0);
        wait_valid(0, 20, e, b);
        check_eq("neg_latency", e,     32'd3);
        check_eq("neg_i_out",   i_out, 32'hFFFE_0000);
        tick();
        pulse_step(0);
        wait_valid(0, 20, e, b);
        check_eq("neg_decay_i_out", i_out, 32'hFFFE_4000);
        tick();

        // ---------------- reset in the middle of DRAIN ----------------
        push(0, 32'h0001_0000);
        push(0, 32'h0001_0000);
        push(0, 32'h0001_0000);
        pulse_step(0);   // E0
        tick();          // E1: DECAY -> DRAIN
        check_eq("mid_busy_before", busy,       32'h1);
        check_eq("mid_count_before", fifo_count, 32'd3);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_i_out",   i_out,        32'h0);
        check_eq("mid_rst_i_valid", i_valid,      32'h0);
        check_eq("mid_rst_busy",    busy,         32'h0);
        check_eq("mid_rst_count",   fifo_count,   32'd0);
        check_eq("mid_rst_ready",   ev_ready,     32'h1);
        check_eq("mid_rst_overrun", step_overrun, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // Queued events were discarded: an empty step publishes 0.
        pulse_step(0);
        wait_valid(0, 20, e, b);
        check_eq("post_rst_latency", e,     32'd2);
        check_eq("post_rst_i_out",   i_out, 32'h0);
        tick();

        // ---------------- FIFO full, held 9th event ----------------
        ev_valid  = 1'b1;
        ev_weight = 32'h0000_8000;
        repeat (8) tick();
        check_eq("full_count",   fifo_count, 32'd8);
        check_eq("full_ready",   ev_ready,   32'h0);
        tick();
        check_eq("full_held_count", fifo_count, 32'd8);
        step = 1'b1;
        tick();          // E0, snap = 8
        step = 1'b0;
        k = 0;
        while (k < 20) begin
            if (ev_ready) begin
                tick();  // this edge accepts the held event
                k++;
                ev_valid = 1'b0;
                break;
            end
            tick();
            k++;
        end
        check_eq("full_accept_edge", k, 32'd3);
        wait_valid(0, 30, e, b);
        check_eq("full_latency", (e < 0) ? -1 : k + e, 32'd10);
        check_eq("full_i_out",   i_out, 32'h0004_0000);
        tick();
        check_eq("full_left_count", fifo_count, 32'd1);

        // ---------------- step while busy ----------------
        step = 1'b1;
        tick();          // E0, snap = 1 (the 0.5 left over)
        tick();          // E1 while in DECAY: ignored, flagged
        step = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i_valid) pulses++;
            tick();
        end
        check_eq("ovr_pulses",  pulses,       32'd1);
        check_eq("ovr_flag",    step_overrun, 32'h1);
        check_eq("ovr_i_out",   i_out,        32'h0004_0000);
        check_eq("ovr_count",   fifo_count,   32'd0);
        pulse_step(0);
        wait_valid(0, 20, e, b);
        check_eq("ovr_next_i_out", i_out,        32'h0003_8000);
        check_eq("ovr_sticky",     step_overrun, 32'h1);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("ovr_cleared", step_overrun, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- overflow handling (DECAY_SHIFT=31) ----------------
        push(1, 32'h7FFF_0000);
        pulse_step(1);
        wait_valid(1, 20, e, b);
        check_eq("sat_load_i_out", i_out_b, 32'h7FFF_0000);
        tick();
        push(1, 32'h0010_0000);
        pulse_step(1);
        wait_valid(1, 20, e, b);
`ifdef SYNAPTIC_SATURATE_EN
        check_eq("ovf_pos_i_out", i_out_b, 32'h7FFF_FFFF);
`else
        check_eq("ovf_pos_i_out", i_out_b, 32'h800F_0000);
`endif
        tick();
        push(1, 32'h8000_0000);
        pulse_step(1);
        wait_valid(1, 20, e, b);
`ifdef SYNAPTIC_SATURATE_EN
        // 0x7FFFFFFF + 0x80000000: no overflow
        check_eq("ovf_neg_i_out", i_out_b, 32'hFFFF_FFFF);
`else
        // 0x800F0000 decays by -1 to 0x800F0001, then wraps on adding 0x80000000
        check_eq("ovf_neg_i_out", i_out_b, 32'h000F_0001);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
